// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    StLen0,
    StLen1,
    StData,
    StCsum,
    StDone,
    StErr
  } state_e;

  localparam int unsigned LEN_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned CSUM_W         = 8;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs accepted payload bytes into little-endian words and keeps the running XOR checksum.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        byte_valid_i,
  input  logic [7:0]                  byte_i,
  output logic                        last_byte_o,
  output logic                        word_valid_o,
  output logic [8*BYTES_PER_WORD-1:0] word_o,
  output logic [CSUM_W-1:0]           csum_o
);

  localparam int unsigned WordW = 8 * BYTES_PER_WORD;

  logic [1:0]        cnt_q, cnt_d;
  logic [WordW-1:0]  shift_q, shift_d;
  logic [WordW-1:0]  word_q, word_d;
  logic              valid_q, valid_d;
  logic [CSUM_W-1:0] xor_q, xor_d;

  // Current byte completes a word when the counter sits on the last lane.
  assign last_byte_o  = (cnt_q == 2'(BYTES_PER_WORD - 1));
  assign word_valid_o = valid_q;
  assign word_o       = word_q;
  assign csum_o       = xor_q;

  // Shift new bytes in from the top so the first byte lands in [7:0] after four.
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    word_d  = word_q;
    valid_d = 1'b0;
    xor_d   = xor_q;
    if (byte_valid_i) begin
      shift_d = {byte_i, shift_q[WordW-1:8]};
      cnt_d   = cnt_q + 2'd1;
      xor_d   = xor_q ^ byte_i;
      if (last_byte_o) begin
        valid_d = 1'b1;
        word_d  = shift_d;
      end
    end
  end

  // Assembler state register, cleared by the loader reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      shift_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      xor_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      xor_q   <= xor_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a framed, checksummed byte stream into instruction memory and releases the CPU reset.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_waddr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err
);

  localparam int unsigned MaxWords = 32'd1 << ADDR_W;

  state_e            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [15:0]       words_left_q, words_left_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              cpu_rst_q, done_q, err_q;

  logic              accept;
  logic              last_byte;
  logic              word_valid;
  logic [CSUM_W-1:0] csum;
  logic [15:0]       len;

  assign accept = rx_valid && rx_ready;
  assign len    = {rx_data, len_lo_q};

  // Ready depends only on the registered state.
  assign rx_ready = (state_q != StDone) && (state_q != StErr);

  word_assembler u_word_assembler (
    .clk_i        (clk_in),
    .rst_i        (reset),
    .byte_valid_i (accept && (state_q == StData)),
    .byte_i       (rx_data),
    .last_byte_o  (last_byte),
    .word_valid_o (word_valid),
    .word_o       (im_wdata),
    .csum_o       (csum)
  );

  assign im_we     = word_valid;
  assign im_waddr  = waddr_q;
  assign cpu_rst   = cpu_rst_q;
  assign load_done = done_q;
  assign load_err  = err_q;

  // Frame FSM, remaining-word count and write address advance.
  always_comb begin
    state_d      = state_q;
    len_lo_d     = len_lo_q;
    words_left_d = words_left_q;
    waddr_d      = waddr_q;
    // Address moves on once the write pulse has been presented.
    if (word_valid) begin
      waddr_d = waddr_q + ADDR_W'(1);
    end
    unique case (state_q)
      StLen0: begin
        if (accept) begin
          len_lo_d = rx_data;
          state_d  = StLen1;
        end
      end
      StLen1: begin
        if (accept) begin
          words_left_d = len;
          if (32'(len) > MaxWords) begin
            state_d = StErr;
          end else if (len == 16'd0) begin
            state_d = StCsum;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept && last_byte) begin
          words_left_d = words_left_q - 16'd1;
          if (words_left_q == 16'd1) begin
            state_d = StCsum;
          end
        end
      end
      StCsum: begin
        if (accept) begin
          state_d = (rx_data == csum) ? StDone : StErr;
        end
      end
      StDone, StErr: begin
        state_d = state_q;
      end
      default: state_d = StLen0;
    endcase
  end

  // State and status registers; status follows the next state so it lands one cycle after CSUM.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q      <= StLen0;
      len_lo_q     <= '0;
      words_left_q <= '0;
      waddr_q      <= '0;
      cpu_rst_q    <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      words_left_q <= words_left_d;
      waddr_q      <= waddr_d;
      cpu_rst_q    <= (state_d != StDone);
      done_q       <= (state_d == StDone);
      err_q        <= (state_d == StErr);
    end
  end

endmodule
